// File: rtl/cheri_pkg.sv
// Shared types and encoding constants for the CHERI instruction encoder.
package cheri_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_CHERI  = 7'h5b;
  localparam logic [6:0] OPC_AUIPCC = 7'h17;
  localparam logic [6:0] OPC_AUICGP = 7'h7b;
  localparam logic [6:0] OPC_CJALR  = 7'h67;
  localparam logic [6:0] OPC_CJAL   = 7'h6f;
  localparam logic [6:0] OPC_CLC    = 7'h03;
  localparam logic [6:0] OPC_CSC    = 7'h23;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_ADDI   = 7'h13;

  // func7 for the three-register CHERI forms
  localparam logic [6:0] F7_CSPECIALRW     = 7'h01;
  localparam logic [6:0] F7_CSETBOUNDS     = 7'h08;
  localparam logic [6:0] F7_CSETBOUNDSEXACT = 7'h09;
  localparam logic [6:0] F7_CSEAL          = 7'h0b;
  localparam logic [6:0] F7_CUNSEAL        = 7'h0c;
  localparam logic [6:0] F7_CANDPERM       = 7'h0d;
  localparam logic [6:0] F7_CSETADDR       = 7'h10;
  localparam logic [6:0] F7_CINCADDR       = 7'h11;
  localparam logic [6:0] F7_CSUB           = 7'h14;
  localparam logic [6:0] F7_CSETHIGH       = 7'h16;
  localparam logic [6:0] F7_CTESTSUBSET    = 7'h20;
  localparam logic [6:0] F7_CSETEQUALEXACT = 7'h21;
  localparam logic [6:0] F7_UNARY          = 7'h7f;

  // Sub-functions carried in [24:20] of the unary form
  localparam logic [4:0] SUB_GETPERM  = 5'h00;
  localparam logic [4:0] SUB_GETTYPE  = 5'h01;
  localparam logic [4:0] SUB_GETBASE  = 5'h02;
  localparam logic [4:0] SUB_GETLEN   = 5'h03;
  localparam logic [4:0] SUB_GETTAG   = 5'h04;
  localparam logic [4:0] SUB_CRRL     = 5'h08;
  localparam logic [4:0] SUB_CRAM     = 5'h09;
  localparam logic [4:0] SUB_CMOVE    = 5'h0a;
  localparam logic [4:0] SUB_CLEARTAG = 5'h0b;
  localparam logic [4:0] SUB_GETADDR  = 5'h0f;
  localparam logic [4:0] SUB_GETHIGH  = 5'h17;
  localparam logic [4:0] SUB_GETTOP   = 5'h18;

  typedef enum logic [5:0] {
    OP_CSPECIALRW     = 6'd0,
    OP_CSETBOUNDS     = 6'd1,
    OP_CSETBOUNDSEXACT = 6'd2,
    OP_CSEAL          = 6'd3,
    OP_CUNSEAL        = 6'd4,
    OP_CANDPERM       = 6'd5,
    OP_CSETADDR       = 6'd6,
    OP_CINCADDR       = 6'd7,
    OP_CSUB           = 6'd8,
    OP_CSETHIGH       = 6'd9,
    OP_CTESTSUBSET    = 6'd10,
    OP_CSETEQUALEXACT = 6'd11,
    OP_CGETPERM       = 6'd12,
    OP_CGETTYPE       = 6'd13,
    OP_CGETBASE       = 6'd14,
    OP_CGETLEN        = 6'd15,
    OP_CGETTAG        = 6'd16,
    OP_CRRL           = 6'd17,
    OP_CRAM           = 6'd18,
    OP_CMOVE          = 6'd19,
    OP_CCLEARTAG      = 6'd20,
    OP_CGETADDR       = 6'd21,
    OP_CGETHIGH       = 6'd22,
    OP_CGETTOP        = 6'd23,
    OP_CINCADDRIMM    = 6'd24,
    OP_CSETBOUNDSIMM  = 6'd25,
    OP_AUIPCC         = 6'd26,
    OP_AUICGP         = 6'd27,
    OP_CJALR          = 6'd28,
    OP_CJAL           = 6'd29,
    OP_CLC            = 6'd30,
    OP_CSC            = 6'd31
  } cheri_enc_op_e;

  // Which word of a request the packer should form
  typedef enum logic [1:0] {
    PH_FIRST = 2'd0,
    PH_ADDI  = 2'd1,
    PH_MAIN  = 2'd2
  } cheri_phase_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EMIT_LUI  = 2'd1,
    ST_EMIT_ADDI = 2'd2,
    ST_EMIT_MAIN = 2'd3
  } cheri_state_e;

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

endpackage

// File: rtl/cheri_instr_pack.sv
// Combinational word former: one request plus a phase select gives one 32-bit word.
module cheri_instr_pack
  import cheri_pkg::*;
#(
  parameter logic [4:0] ScratchReg = 5'd31
) (
  input  cheri_enc_op_e      op_i,
  input  logic [4:0]         rd_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic signed [20:0] imm_i,
  input  cheri_phase_e       phase_i,
  output logic [31:0]        word_o,
  output logic               err_o,
  output logic               expand_o
);

  logic        fits12;
  logic [31:0] lui_sum;

  // Immediate fits a signed 12-bit field when bits [20:11] are pure sign extension
  assign fits12 = (imm_i[20:11] == {10{imm_i[11]}});

  // Select encoding per op; illegal requests collapse to an all-zero word
  always_comb begin
    word_o   = '0;
    err_o    = 1'b0;
    expand_o = 1'b0;
    // Rounded upper part so the following ADDI's sign-extended low part lands exactly
    lui_sum  = {11'b0, imm_i} + 32'h0000_0800;
    case (op_i)
      OP_CSPECIALRW:      word_o = enc_r(F7_CSPECIALRW, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CSETBOUNDS:      word_o = enc_r(F7_CSETBOUNDS, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CSETBOUNDSEXACT: word_o = enc_r(F7_CSETBOUNDSEXACT, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CSEAL:           word_o = enc_r(F7_CSEAL, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CUNSEAL:         word_o = enc_r(F7_CUNSEAL, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CANDPERM:        word_o = enc_r(F7_CANDPERM, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CSETADDR:        word_o = enc_r(F7_CSETADDR, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CINCADDR:        word_o = enc_r(F7_CINCADDR, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CSUB:            word_o = enc_r(F7_CSUB, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CSETHIGH:        word_o = enc_r(F7_CSETHIGH, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CTESTSUBSET:     word_o = enc_r(F7_CTESTSUBSET, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CSETEQUALEXACT:  word_o = enc_r(F7_CSETEQUALEXACT, rs2_i, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CGETPERM:        word_o = enc_r(F7_UNARY, SUB_GETPERM, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CGETTYPE:        word_o = enc_r(F7_UNARY, SUB_GETTYPE, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CGETBASE:        word_o = enc_r(F7_UNARY, SUB_GETBASE, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CGETLEN:         word_o = enc_r(F7_UNARY, SUB_GETLEN, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CGETTAG:         word_o = enc_r(F7_UNARY, SUB_GETTAG, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CRRL:            word_o = enc_r(F7_UNARY, SUB_CRRL, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CRAM:            word_o = enc_r(F7_UNARY, SUB_CRAM, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CMOVE:           word_o = enc_r(F7_UNARY, SUB_CMOVE, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CCLEARTAG:       word_o = enc_r(F7_UNARY, SUB_CLEARTAG, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CGETADDR:        word_o = enc_r(F7_UNARY, SUB_GETADDR, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CGETHIGH:        word_o = enc_r(F7_UNARY, SUB_GETHIGH, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CGETTOP:         word_o = enc_r(F7_UNARY, SUB_GETTOP, rs1_i, 3'b000, rd_i, OPC_CHERI);
      OP_CINCADDRIMM: begin
        err_o  = ~fits12;
        word_o = enc_i(imm_i[11:0], rs1_i, 3'b001, rd_i, OPC_CHERI);
      end
      OP_CSETBOUNDSIMM: begin
        if (imm_i[20]) begin
          err_o = 1'b1;
        end else if (imm_i[19:12] != 8'd0) begin
          // Too wide for the 12-bit field: build the length in the scratch register
          expand_o = 1'b1;
          err_o    = (rs1_i == ScratchReg);
          case (phase_i)
            PH_FIRST: word_o = (lui_sum & 32'hFFFF_F000) | {20'b0, ScratchReg, OPC_LUI};
            PH_ADDI:  word_o = enc_i(imm_i[11:0], ScratchReg, 3'b000, ScratchReg, OPC_ADDI);
            default:  word_o = enc_r(F7_CSETBOUNDS, ScratchReg, rs1_i, 3'b000, rd_i, OPC_CHERI);
          endcase
        end else begin
          word_o = enc_i(imm_i[11:0], rs1_i, 3'b010, rd_i, OPC_CHERI);
        end
      end
      OP_AUIPCC: word_o = {imm_i[19:0], rd_i, OPC_AUIPCC};
      OP_AUICGP: word_o = {imm_i[19:0], rd_i, OPC_AUICGP};
      OP_CJALR: begin
        err_o  = ~fits12;
        word_o = enc_i(imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_CJALR);
      end
      OP_CJAL: begin
        err_o  = imm_i[0];
        word_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_CJAL};
      end
      OP_CLC: begin
        err_o  = ~fits12;
        word_o = enc_i(imm_i[11:0], rs1_i, 3'b011, rd_i, OPC_CLC);
      end
      OP_CSC: begin
        err_o  = ~fits12;
        word_o = {imm_i[11:5], rs2_i, rs1_i, 3'b011, imm_i[4:0], OPC_CSC};
      end
      default: err_o = 1'b1;
    endcase
    if (err_o) begin
      word_o   = '0;
      expand_o = 1'b0;
    end
  end

endmodule

// File: rtl/cheri_instr_encoder.sv
// CHERI instruction encoder: request handshake in, one registered word per output handshake.
//
//   state        | meaning
//   ST_IDLE      | output register empty or holding a single-word result
//   ST_EMIT_LUI  | output register holds LUI of a 3-word CSetBoundsImm expansion
//   ST_EMIT_ADDI | output register holds the ADDI of the expansion
//   ST_EMIT_MAIN | output register holds the final CSetBounds of the expansion
module cheri_instr_encoder
  import cheri_pkg::*;
#(
  parameter logic [4:0] ScratchReg = 5'd31
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  cheri_enc_op_e      req_op_i,
  input  logic [4:0]         req_rd_i,
  input  logic [4:0]         req_rs1_i,
  input  logic [4:0]         req_rs2_i,
  input  logic signed [20:0] req_imm_i,
  output logic               instr_valid_o,
  input  logic               instr_ready_i,
  output logic [31:0]        instr_o,
  output logic               instr_err_o,
  input  logic               flush_i,
  output logic [15:0]        count_o
);

  cheri_state_e       state_q, state_d;
  logic               valid_q, valid_d;
  logic [31:0]        instr_q, instr_d;
  logic               err_q, err_d;
  logic [15:0]        count_q;
  cheri_enc_op_e      op_q;
  logic [4:0]         rd_q, rs1_q;
  logic signed [20:0] imm_q;

  logic               in_idle, out_hs, accept;
  cheri_enc_op_e      pk_op;
  logic [4:0]         pk_rd, pk_rs1;
  logic signed [20:0] pk_imm;
  cheri_phase_e       pk_phase;
  logic [31:0]        pk_word;
  logic               pk_err, pk_expand;

  assign in_idle     = (state_q == ST_IDLE);
  assign out_hs      = valid_q & instr_ready_i;
  assign req_ready_o = in_idle & (~valid_q | instr_ready_i) & ~flush_i;
  assign accept      = req_valid_i & req_ready_o;

  // Live request feeds the packer in IDLE; the captured request feeds later expansion words
  always_comb begin
    pk_op    = req_op_i;
    pk_rd    = req_rd_i;
    pk_rs1   = req_rs1_i;
    pk_imm   = req_imm_i;
    pk_phase = PH_FIRST;
    if (!in_idle) begin
      pk_op    = op_q;
      pk_rd    = rd_q;
      pk_rs1   = rs1_q;
      pk_imm   = imm_q;
      pk_phase = (state_q == ST_EMIT_LUI) ? PH_ADDI : PH_MAIN;
    end
  end

  cheri_instr_pack #(
    .ScratchReg(ScratchReg)
  ) u_pack (
    .op_i    (pk_op),
    .rd_i    (pk_rd),
    .rs1_i   (pk_rs1),
    .rs2_i   (req_rs2_i),
    .imm_i   (pk_imm),
    .phase_i (pk_phase),
    .word_o  (pk_word),
    .err_o   (pk_err),
    .expand_o(pk_expand)
  );

  // Next state and output-register contents
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    instr_d = instr_q;
    err_d   = err_q;
    if (flush_i) begin
      state_d = ST_IDLE;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            valid_d = 1'b1;
            instr_d = pk_word;
            err_d   = pk_err;
            if (pk_expand) state_d = ST_EMIT_LUI;
          end else if (out_hs) begin
            valid_d = 1'b0;
          end
        end
        ST_EMIT_LUI: begin
          if (out_hs) begin
            instr_d = pk_word;
            err_d   = 1'b0;
            state_d = ST_EMIT_ADDI;
          end
        end
        ST_EMIT_ADDI: begin
          if (out_hs) begin
            instr_d = pk_word;
            err_d   = 1'b0;
            state_d = ST_EMIT_MAIN;
          end
        end
        default: begin
          if (out_hs) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
      endcase
    end
  end

  // State, output register and delivered-word counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      instr_q <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      if (out_hs && !flush_i && count_q != 16'hFFFF) count_q <= count_q + 16'd1;
    end
  end

  // Hold the accepted request for the remaining expansion words
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q  <= OP_CSPECIALRW;
      rd_q  <= '0;
      rs1_q <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= req_op_i;
      rd_q  <= req_rd_i;
      rs1_q <= req_rs1_i;
      imm_q <= req_imm_i;
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_err_o   = err_q;
  assign count_o       = count_q;

endmodule

// File: tb/tb_cheri_instr_encoder.sv
// Directed bench for cheri_instr_encoder with hand-computed expected words.
module tb_cheri_instr_encoder;
  import cheri_pkg::*;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               req_valid_i = 1'b0;
  logic               req_ready_o;
  cheri_enc_op_e      req_op_i = OP_CSPECIALRW;
  logic [4:0]         req_rd_i = '0;
  logic [4:0]         req_rs1_i = '0;
  logic [4:0]         req_rs2_i = '0;
  logic signed [20:0] req_imm_i = '0;
  logic               instr_valid_o;
  logic               instr_ready_i = 1'b1;
  logic [31:0]        instr_o;
  logic               instr_err_o;
  logic               flush_i = 1'b0;
  logic [15:0]        count_o;

  int total = 0;
  int bad = 0;

  cheri_instr_encoder #(.ScratchReg(5'd31)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_op_i     (req_op_i),
    .req_rd_i     (req_rd_i),
    .req_rs1_i    (req_rs1_i),
    .req_rs2_i    (req_rs2_i),
    .req_imm_i    (req_imm_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o      (instr_o),
    .instr_err_o  (instr_err_o),
    .flush_i      (flush_i),
    .count_o      (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one request for a single cycle; it is accepted at the next edge
  task automatic send(input cheri_enc_op_e op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic signed [20:0] imm);
    req_op_i    = op;
    req_rd_i    = rd;
    req_rs1_i   = rs1;
    req_rs2_i   = rs2;
    req_imm_i   = imm;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    logic [4:0]  rdv;

    // Reset
    step(); step();
    chk("rst_valid", 32'(instr_valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_err", 32'(instr_err_o), 32'd0);
    chk("rst_count", 32'(count_o), 32'd0);
    #2 rst_ni = 1'b1;
    step();
    chk("rst_ready", 32'(req_ready_o), 32'd1);

    // CIncAddrImm rd=5 rs1=6 imm=-1
    send(OP_CINCADDRIMM, 5'd5, 5'd6, 5'd0, -21'sd1);
    chk("incimm_valid", 32'(instr_valid_o), 32'd1);
    chk("incimm_word", instr_o, 32'hFFF3_12DB);
    chk("incimm_err", 32'(instr_err_o), 32'd0);
    step();
    chk("incimm_count", 32'(count_o), 32'd1);
    chk("incimm_drained", 32'(instr_valid_o), 32'd0);

    // CGetLen unary form
    send(OP_CGETLEN, 5'd10, 5'd11, 5'd0, 21'sd0);
    chk("getlen_rd10", instr_o, 32'hFE35_855B);
    step();
    send(OP_CGETLEN, 5'd0, 5'd11, 5'd0, 21'sd0);
    chk("getlen_rd0", instr_o, 32'hFE35_805B);
    step();
    chk("getlen_count", 32'(count_o), 32'd3);

    // CSetBoundsImm 0x1800 expands to LUI / ADDI / CSetBounds
    send(OP_CSETBOUNDSIMM, 5'd8, 5'd9, 5'd0, 21'sh1800);
    chk("exp_lui", instr_o, 32'h0000_2FB7);
    chk("exp_lui_ready", 32'(req_ready_o), 32'd0);
    step();
    chk("exp_addi", instr_o, 32'h800F_8F93);
    chk("exp_addi_ready", 32'(req_ready_o), 32'd0);
    step();
    chk("exp_main", instr_o, 32'h11F4_845B);
    chk("exp_main_ready", 32'(req_ready_o), 32'd0);
    step();
    chk("exp_done_valid", 32'(instr_valid_o), 32'd0);
    chk("exp_done_ready", 32'(req_ready_o), 32'd1);
    chk("exp_count", 32'(count_o), 32'd6);

    // Output stall holds the word and blocks new requests
    instr_ready_i = 1'b0;
    send(OP_AUIPCC, 5'd1, 5'd0, 5'd0, 21'sh12345);
    held = instr_o;
    chk("auipcc_word", held, 32'h1234_5097);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_word", instr_o, 32'h1234_5097);
      chk("stall_ready", 32'(req_ready_o), 32'd0);
    end
    instr_ready_i = 1'b1;
    step();
    chk("stall_count", 32'(count_o), 32'd7);

    // 10 back-to-back CIncAddr requests, one word per cycle
    for (int i = 0; i < 10; i++) begin
      rdv = 5'(i);
      req_op_i    = OP_CINCADDR;
      req_rd_i    = rdv;
      req_rs1_i   = 5'd1;
      req_rs2_i   = 5'd2;
      req_imm_i   = '0;
      req_valid_i = 1'b1;
      chk("b2b_ready", 32'(req_ready_o), 32'd1);
      step();
      chk("b2b_valid", 32'(instr_valid_o), 32'd1);
      chk("b2b_word", instr_o, {7'h11, 5'd2, 5'd1, 3'b000, rdv, 7'h5b});
    end
    req_valid_i = 1'b0;
    step();
    chk("b2b_count", 32'(count_o), 32'd17);

    // Illegal requests and boundary legal ones
    send(OP_CJAL, 5'd1, 5'd0, 5'd0, 21'sd3);
    chk("cjal_odd_word", instr_o, 32'd0);
    chk("cjal_odd_err", 32'(instr_err_o), 32'd1);
    step();
    chk("cjal_odd_count", 32'(count_o), 32'd18);
    send(OP_CINCADDRIMM, 5'd5, 5'd6, 5'd0, 21'sd4096);
    chk("incimm_big_err", 32'(instr_err_o), 32'd1);
    chk("incimm_big_word", instr_o, 32'd0);
    step();
    send(OP_CJAL, 5'd1, 5'd0, 5'd0, -21'sd4);
    chk("cjal_neg4_word", instr_o, 32'hFFDF_F0EF);
    chk("cjal_neg4_err", 32'(instr_err_o), 32'd0);
    step();
    send(cheri_enc_op_e'(6'd40), 5'd1, 5'd2, 5'd3, 21'sd0);
    chk("undef_err", 32'(instr_err_o), 32'd1);
    step();
    send(OP_CSETBOUNDSIMM, 5'd1, 5'd2, 5'd0, -21'sd16);
    chk("setbimm_neg_err", 32'(instr_err_o), 32'd1);
    step();
    send(OP_CSETBOUNDSIMM, 5'd1, 5'd31, 5'd0, 21'sh1800);
    chk("scratch_rs1_err", 32'(instr_err_o), 32'd1);
    chk("scratch_rs1_word", instr_o, 32'd0);
    step();
    chk("scratch_rs1_single", 32'(req_ready_o), 32'd1);
    send(OP_CSC, 5'd0, 5'd2, 5'd3, -21'sd8);
    chk("csc_word", instr_o, 32'hFE31_3C23);
    step();
    chk("err_count", 32'(count_o), 32'd24);

    // Flush while the ADDI word is pending
    send(OP_CSETBOUNDSIMM, 5'd8, 5'd9, 5'd0, 21'sh1800);
    step();
    chk("flush_pre_addi", instr_o, 32'h800F_8F93);
    flush_i = 1'b1;
    #1;
    chk("flush_ready", 32'(req_ready_o), 32'd0);
    step();
    flush_i = 1'b0;
    #1;
    chk("flush_valid", 32'(instr_valid_o), 32'd0);
    chk("flush_idle_ready", 32'(req_ready_o), 32'd1);
    chk("flush_count", 32'(count_o), 32'd25);
    step(); step();
    chk("flush_no_more", 32'(instr_valid_o), 32'd0);
    chk("flush_count_hold", 32'(count_o), 32'd25);

    // Reset in the middle of an expansion
    instr_ready_i = 1'b0;
    send(OP_CSETBOUNDSIMM, 5'd8, 5'd9, 5'd0, 21'sh1800);
    chk("mid_lui", instr_o, 32'h0000_2FB7);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(instr_valid_o), 32'd0);
    chk("mid_rst_instr", instr_o, 32'd0);
    chk("mid_rst_err", 32'(instr_err_o), 32'd0);
    chk("mid_rst_count", 32'(count_o), 32'd0);
    step();
    rst_ni = 1'b1;
    instr_ready_i = 1'b1;
    step();
    chk("post_rst_ready", 32'(req_ready_o), 32'd1);
    step(); step();
    chk("post_rst_valid", 32'(instr_valid_o), 32'd0);
    chk("post_rst_count", 32'(count_o), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
